// File: rtl/seq_mul_param.sv
// Sequential shift-and-add multiplier with configurable width/radix, signed mode, handshakes
// and stall. Define CONST_TIME_EN to disable early termination (RUN always lasts N cycles).
module seq_mul_param #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned RADIX_LOG = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 signed_mode,
   input  logic                 stall,
   output logic [2*WIDTH-1:0]   o,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 busy
);

   localparam int unsigned N    = WIDTH / RADIX_LOG;
   localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned ShW  = $clog2(WIDTH) + 1;

   localparam logic [CntW-1:0]  CntLast = CntW'(N - 1);
   localparam logic [ShW-1:0]   ShStep  = ShW'(RADIX_LOG);
   localparam logic [WIDTH-1:0] OneW    = WIDTH'(1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e               state_q, state_d;
   logic [WIDTH-1:0]     a_mag_q, a_mag_d;
   logic [WIDTH-1:0]     b_mag_q, b_mag_d;
   logic                 neg_q, neg_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [ShW-1:0]       shift_q, shift_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   o_q, o_d;

   logic [WIDTH-1:0]     a_abs, b_abs;
   logic [2*WIDTH-1:0]   a_ext, d_ext, acc_next;
   logic                 last;

   // |x| of the most negative value wraps to 2^(W-1), which is the correct unsigned magnitude.
   always_comb begin
      a_abs = (signed_mode && a[WIDTH-1]) ? (~a + OneW) : a;
      b_abs = (signed_mode && b[WIDTH-1]) ? (~b + OneW) : b;
   end

   always_comb begin
      a_ext = '0;
      d_ext = '0;
      a_ext[WIDTH-1:0]     = a_mag_q;
      d_ext[RADIX_LOG-1:0] = b_mag_q[RADIX_LOG-1:0];
      acc_next = acc_q + ((a_ext * d_ext) << shift_q);
   end

`ifdef CONST_TIME_EN
   assign last = (cnt_q == CntLast);
`else
   assign last = (cnt_q == CntLast) || ((b_mag_q >> RADIX_LOG) == '0) || (a_mag_q == '0);
`endif

   always_comb begin
      state_d = state_q;
      a_mag_d = a_mag_q;
      b_mag_d = b_mag_q;
      neg_d   = neg_q;
      acc_d   = acc_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      o_d     = o_q;
      if (!stall) begin
         unique case (state_q)
            StIdle: begin
               if (in_valid) begin
                  a_mag_d = a_abs;
                  b_mag_d = b_abs;
                  neg_d   = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                  acc_d   = '0;
                  shift_d = '0;
                  cnt_d   = '0;
                  state_d = StRun;
               end
            end
            StRun: begin
               acc_d   = acc_next;
               b_mag_d = b_mag_q >> RADIX_LOG;
               shift_d = shift_q + ShStep;
               cnt_d   = cnt_q + 1'b1;
               if (last) begin
                  o_d     = neg_q ? -acc_next : acc_next;
                  state_d = StDone;
               end
            end
            StDone: begin
               if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         a_mag_q <= '0;
         b_mag_q <= '0;
         neg_q   <= 1'b0;
         acc_q   <= '0;
         shift_q <= '0;
         cnt_q   <= '0;
         o_q     <= '0;
      end else begin
         state_q <= state_d;
         a_mag_q <= a_mag_d;
         b_mag_q <= b_mag_d;
         neg_q   <= neg_d;
         acc_q   <= acc_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         o_q     <= o_d;
      end
   end

   assign in_ready  = (state_q == StIdle) && !stall;
   assign out_valid = (state_q == StDone);
   assign busy      = (state_q != StIdle);
   assign o         = out_valid ? o_q : '0;

endmodule

// File: doc/seq_mul_param.md
Name: seq_mul_param

Overview:
Parametrised sequential shift-and-add multiplier. Successor to the fixed-width unsigned MUL used in the contract-miter experiments. Adds:
- configurable operand width and radix (bits retired per step)
- signed/unsigned mode per operation
- valid/ready handshakes on both sides
- external stall
- compile-time option for data-independent latency

Two copies of this block are instantiated in contract-check miters, so timing behaviour must be exactly as specified.

Parameters:
WIDTH, 8, operand width in bits; ≥2.
RADIX_LOG, 1, multiplier bits consumed per RUN cycle; must divide WIDTH; N = WIDTH/RADIX_LOG steps max.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  reset, asynchronous, active-low.
in_valid  input  1  operands offered.
in_ready  output  1  block can accept operands.
a  input  WIDTH  multiplicand.
b  input  WIDTH  multiplier.
signed_mode  input  1  sampled with operands; 1 = two's-complement operands and result.
stall  input  1  freeze all internal state and both handshakes.
o  output  2*WIDTH  product; valid only while out_valid=1, else 0.
out_valid  output  1  result available.
out_ready  input  1  consumer takes result.
busy  output  1  state != IDLE.

Behaviour:
- Clock and reset (already decided): one clock; reset is asynchronous and active-low.
- Reset: state=IDLE; all registers 0. Outputs: in_ready=1 if stall=0, out_valid=0, o=0, busy=0. Reset mid-operation discards the operation with no output.
- States:
  - IDLE: in_ready = !stall. Accept when in_valid && in_ready.
    - Latch a_mag = |a| and b_mag = |b| if signed_mode, else raw values.
    - Latch neg = signed_mode & (a[W-1] ^ b[W-1]).
    - acc=0, shift=0, cnt=0. Go to RUN.
  - RUN: each non-stalled cycle:
    - acc += (a_mag * b_mag[RADIX_LOG-1:0]) << shift
    - b_mag >>= RADIX_LOG
    - shift += RADIX_LOG
    - cnt++
  - RUN → DONE on the same edge if cnt==N-1, or (early termination) (b_mag>>RADIX_LOG)==0, or a_mag==0.
    - On that edge, o register <= neg ? -(acc_next) mod 2^(2W) : acc_next.
  - DONE: out_valid=1, o=result. DONE → IDLE when out_ready && !stall.
- Latency: RUN cycles L = max(1, number of significant RADIX_LOG-bit digits of b_mag).
  - L=1 if a_mag==0.
  - out_valid rises L+1 cycles after the acceptance edge, plus stalled cycles.
- No new input is accepted while busy; in_valid is ignored outside IDLE.
- Stall in any state holds every register. in_ready=0 and no DONE→IDLE transition under stall; out_valid and o stay stable.
- Arithmetic:
  - The magnitude of -2^(W-1) is 2^(W-1) in W unsigned bits.
  - Product magnitude fits in 2W bits.
  - The final negation is modulo 2^(2W); -0 = 0.
- in_valid && out_ready in the same cycle has no interaction: the result is drained first, and the next operand is accepted in IDLE in a later cycle.

Optional Feature:
CONST_TIME_EN
- Defined: early termination disabled. RUN always takes exactly N cycles and out_valid rises N+1 cycles after acceptance (plus stalls), independent of operand values. Result is identical.
- Undefined: early-termination latency as above.

Test Plan:
1. WIDTH=8, RADIX_LOG=1, unsigned: a=13, b=11 -> o=0x008F; out_valid 5 cycles after acceptance (L=4). With CONST_TIME_EN: 9 cycles.
2. Signed: a=0xFD (-3), b=0x05 -> o=0xFFF1 (-15), L=3. Also a=0x80, b=0x80 -> o=0x4000, L=8.
3. RADIX_LOG=2, unsigned: a=0xFF, b=0xFF -> o=0xFE01, L=4. Then a=0, b=0xFF -> o=0, L=1 (CONST_TIME_EN: L=4).
4. Stall held 3 cycles mid-RUN on case 1 -> same o=0x008F; out_valid delayed exactly 3 cycles. Stall in DONE with out_ready=1 -> out_valid and o held.
5. Backpressure: out_ready=0 for 5 cycles after DONE -> o/out_valid stable, in_ready=0, a second in_valid pulse ignored. out_ready=1 -> IDLE next cycle, in_ready=1.
6. rst_n low during RUN -> out_valid=0, busy=0, o=0 immediately. After release, a new a=2, b=3 yields o=6.
